channel_buffer: RTL and testbench

- Per-channel input FIFO directly upstream of the 4-input buffer mux; one instance per mux channel drives that channel's in_dataN and consumes its readyN.
- Accepts 35-bit tagged words from a producer and presents them show-ahead to the mux with bit 34 as the valid flag.
- Decouples producer bursts from mux arbitration and from memory back-pressure (next_ready/mem_full).

---
 rtl/buffer_pkg.sv | 22 ++
 rtl/channel_buffer_if.sv | 38 +++
 rtl/channel_buffer_ram.sv | 24 ++
 rtl/channel_buffer.sv | 102 ++++++++++
 tb/tb_channel_buffer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/buffer_pkg.sv
// Shared word format for the channel buffers, the 4-input buffer mux and the memory stage.
package buffer_pkg;

  localparam int WORD_W    = 35;
  localparam int VALID_BIT = 34;
  localparam int PAYLOAD_W = 34;

  typedef logic [WORD_W-1:0] word_t;

  // Encoding matches {pop, accept} so the operation can be formed by a cast.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_POP   = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic logic is_valid(word_t w);
    return w[VALID_BIT];
  endfunction

endpackage

// File: rtl/channel_buffer_if.sv
// Producer/mux-facing signal bundle of one channel_buffer.
// CHANNEL_BUFFER_OVERFLOW_EN adds the overflow and drop_count status signals.
interface channel_buffer_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = buffer_pkg::WORD_W
);

  logic [WIDTH-1:0]        wr_data;
  logic                    full;
  logic [WIDTH-1:0]        out_data;
  logic                    mux_ready;
  logic [$clog2(DEPTH):0]  count;
`ifdef CHANNEL_BUFFER_OVERFLOW_EN
  logic                    overflow;
  logic [7:0]              drop_count;

  modport master (
    output wr_data, mux_ready,
    input  full, out_data, count, overflow, drop_count
  );

  modport slave (
    input  wr_data, mux_ready,
    output full, out_data, count, overflow, drop_count
  );
`else
  modport master (
    output wr_data, mux_ready,
    input  full, out_data, count
  );

  modport slave (
    input  wr_data, mux_ready,
    output full, out_data, count
  );
`endif

endinterface

// File: rtl/channel_buffer_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module channel_buffer_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/channel_buffer.sv
// Show-ahead per-channel FIFO feeding one input of the buffer mux.
// CHANNEL_BUFFER_OVERFLOW_EN adds sticky overflow and a saturating drop counter.
module channel_buffer
  import buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic           clk,
  input  logic           reset,
  channel_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_q;
  logic [WIDTH-1:0] rd_word;
  logic             wr_req;
  logic             accept;
  logic             pop;
  logic             not_empty;
  fifo_op_e         op;

  assign not_empty = (cnt_q != '0);
  assign wr_req    = bus.wr_data[WIDTH-1];
  // full is the registered flag, so a pop in the same cycle never frees room for the write.
  assign accept    = wr_req && !full_q;
  assign pop       = not_empty && bus.mux_ready;
  assign op        = fifo_op_e'({pop, accept});

  always_comb begin
    cnt_d = cnt_q;
    unique case (op)
      OP_WRITE: cnt_d = cnt_q + CNT_W'(1);
      OP_POP:   cnt_d = cnt_q - CNT_W'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CNT_W'(DEPTH));
    end
  end

  channel_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept && !reset),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  assign bus.out_data = not_empty ? rd_word : '0;
  assign bus.full     = full_q;
  assign bus.count    = cnt_q;

`ifdef CHANNEL_BUFFER_OVERFLOW_EN
  logic       overflow_q;
  logic [7:0] drop_cnt_q;
  logic       drop;

  assign drop = wr_req && full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_channel_buffer.sv
// Scoreboard bench for channel_buffer: accepted words are queued, popped words are checked in order.
module tb_channel_buffer;
  import buffer_pkg::*;

  localparam int DEPTH = 4;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  word_t q[$];
  int    checks = 0;
  int    failures = 0;
  int    drops = 0;

  always #5 clk = ~clk;

  channel_buffer_if #(.DEPTH(DEPTH), .WIDTH(WORD_W)) bus ();

  channel_buffer #(.DEPTH(DEPTH), .WIDTH(WORD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Drives one cycle and advances the reference model on the same edge.
  task automatic drive_cycle(input word_t wr, input logic mr, input logic rst);
    int n0;
    bus.wr_data   = wr;
    bus.mux_ready = mr;
    reset         = rst;
    n0 = q.size();
    if (rst) begin
      q.delete();
      drops = 0;
    end else begin
      if (n0 != 0 && mr) void'(q.pop_front());
      if (is_valid(wr) && n0 != DEPTH) q.push_back(wr);
      if (is_valid(wr) && n0 == DEPTH && drops < 255) drops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive_cycle('0, 1'b1, 1'b1);
    drive_cycle('0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle('0, 1'b1, 1'b0);
      checks++;
      if (bus.out_data !== 35'h0) begin
        failures++; $display("FAIL reset_out cyc=%0d got=%h exp=%h", i, bus.out_data, 35'h0);
      end
      checks++;
      if (bus.count !== 3'd0 || bus.full !== 1'b0) begin
        failures++; $display("FAIL reset_cnt cyc=%0d got count=%0d full=%b exp 0/0", i, bus.count, bus.full);
      end
    end
`ifdef CHANNEL_BUFFER_OVERFLOW_EN
    checks++;
    if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
      failures++; $display("FAIL reset_ovf got=%b/%0d exp 0/0", bus.overflow, bus.drop_count);
    end
`endif
  endtask

  task automatic test_single;
    drive_cycle(35'h400000000, 1'b0, 1'b0);
    checks++;
    if (bus.out_data !== 35'h400000000 || bus.count !== 3'd1) begin
      failures++; $display("FAIL single_wr got=%h cnt=%0d exp=%h cnt=1", bus.out_data, bus.count, 35'h400000000);
    end
    checks++;
    if (bus.out_data !== q[0]) begin
      failures++; $display("FAIL single_sb got=%h exp=%h", bus.out_data, q[0]);
    end
    drive_cycle('0, 1'b1, 1'b0);
    checks++;
    if (bus.out_data !== 35'h0 || bus.count !== 3'd0) begin
      failures++; $display("FAIL single_pop got=%h cnt=%0d exp=0 cnt=0", bus.out_data, bus.count);
    end
  endtask

  task automatic test_fill;
    word_t exp;
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(35'h400000000 + 35'(i), 1'b0, 1'b0);
      checks++;
      if (bus.count !== 3'(q.size()) || bus.full !== (q.size() == DEPTH)) begin
        failures++; $display("FAIL fill_cnt wr=%0d got cnt=%0d full=%b exp cnt=%0d", i, bus.count, bus.full, q.size());
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
      failures++; $display("FAIL fill_full got full=%b cnt=%0d exp 1/4", bus.full, bus.count);
    end
`ifdef CHANNEL_BUFFER_OVERFLOW_EN
    checks++;
    if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1) begin
      failures++; $display("FAIL fill_ovf got=%b/%0d exp 1/1", bus.overflow, bus.drop_count);
    end
`endif
    for (int i = 1; i <= 4; i++) begin
      exp = q[0];
      checks++;
      if (bus.out_data !== exp || exp !== 35'h400000000 + 35'(i)) begin
        failures++; $display("FAIL fill_drain idx=%0d got=%h exp=%h", i, bus.out_data, exp);
      end
      drive_cycle('0, 1'b1, 1'b0);
    end
    checks++;
    if (bus.out_data !== 35'h0 || bus.count !== 3'd0 || bus.full !== 1'b0) begin
      failures++; $display("FAIL fill_empty got=%h cnt=%0d full=%b exp 0", bus.out_data, bus.count, bus.full);
    end
  endtask

  task automatic test_full_pop;
    word_t exp;
    for (int i = 0; i < 4; i++) drive_cycle(35'h400000021 + 35'(i), 1'b0, 1'b0);
    drive_cycle(35'h6FFFFFFFF, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 3'd3 || bus.full !== 1'b0) begin
      failures++; $display("FAIL fullpop_drop got cnt=%0d full=%b exp 3/0", bus.count, bus.full);
    end
    drive_cycle(35'h6FFFFFFFF, 1'b0, 1'b0);
    checks++;
    if (bus.count !== 3'd4 || bus.full !== 1'b1) begin
      failures++; $display("FAIL fullpop_retry got cnt=%0d full=%b exp 4/1", bus.count, bus.full);
    end
`ifdef CHANNEL_BUFFER_OVERFLOW_EN
    checks++;
    if (bus.drop_count !== 8'(drops)) begin
      failures++; $display("FAIL fullpop_drops got=%0d exp=%0d", bus.drop_count, drops);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      exp = q[0];
      checks++;
      if (bus.out_data !== exp) begin
        failures++; $display("FAIL fullpop_order idx=%0d got=%h exp=%h", i, bus.out_data, exp);
      end
      drive_cycle('0, 1'b1, 1'b0);
    end
    checks++;
    if (exp !== 35'h6FFFFFFFF || bus.count !== 3'd0) begin
      failures++; $display("FAIL fullpop_last got=%h cnt=%0d exp=6ffffffff cnt=0", exp, bus.count);
    end
  endtask

  task automatic test_stream;
    word_t exp;
    int bad = 0;
    drive_cycle(35'h400000010, 1'b1, 1'b0);
    for (int i = 1; i < 20; i++) begin
      exp = q[0];
      checks++;
      if (bus.out_data !== exp || exp !== 35'h400000010 + 35'(i - 1)) begin
        failures++; $display("FAIL stream_word i=%0d got=%h exp=%h", i, bus.out_data, exp);
      end
      drive_cycle(35'h400000010 + 35'(i), 1'b1, 1'b0);
      if (bus.count !== 3'd1 || bus.full !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL stream_cnt got bad_cycles=%0d exp=0", bad);
    end
    exp = q[0];
    checks++;
    if (bus.out_data !== exp || exp !== 35'h400000023) begin
      failures++; $display("FAIL stream_tail got=%h exp=%h", bus.out_data, exp);
    end
    drive_cycle('0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 3'd0 || bus.out_data !== 35'h0) begin
      failures++; $display("FAIL stream_empty got=%h cnt=%0d exp 0", bus.out_data, bus.count);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) drive_cycle(35'h400000030 + 35'(i), 1'b0, 1'b0);
    checks++;
    if (bus.count !== 3'd3) begin
      failures++; $display("FAIL rstmid_pre got cnt=%0d exp=3", bus.count);
    end
    drive_cycle(35'h400000099, 1'b0, 1'b1);
    checks++;
    if (bus.count !== 3'd0 || bus.out_data !== 35'h0 || bus.full !== 1'b0) begin
      failures++; $display("FAIL rstmid got=%h cnt=%0d full=%b exp 0", bus.out_data, bus.count, bus.full);
    end
`ifdef CHANNEL_BUFFER_OVERFLOW_EN
    checks++;
    if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
      failures++; $display("FAIL rstmid_ovf got=%b/%0d exp 0/0", bus.overflow, bus.drop_count);
    end
`endif
    drive_cycle('0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 3'(q.size()) || bus.out_data !== 35'h0) begin
      failures++; $display("FAIL rstmid_post got=%h cnt=%0d exp 0", bus.out_data, bus.count);
    end
    drive_cycle(35'h400000077, 1'b0, 1'b0);
    checks++;
    if (bus.out_data !== q[0] || bus.count !== 3'd1) begin
      failures++; $display("FAIL rstmid_new got=%h cnt=%0d exp=%h cnt=1", bus.out_data, bus.count, q[0]);
    end
  endtask

  initial begin
    bus.wr_data   = '0;
    bus.mux_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stream();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
